// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio interpolator.
package audio_pkg;

  typedef enum logic {IDLE, RAMP} state_t;

  localparam int RAMP_LOG2_DEFAULT = 8;

endpackage

// File: rtl/audio_interp_ramp.sv
// Ramp arithmetic: step/accumulator; value is combinational and registered by the parent.
// Linear ramp with AUDIO_INTERP_LINEAR_EN defined, zero-order hold otherwise; load overrides advance.
module audio_interp_ramp #(
  parameter int audio_bits = 16,
  parameter int ramp_log2  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [audio_bits-1:0] target_in,
  output logic [audio_bits-1:0] value
);

  localparam int AW = audio_bits + ramp_log2 + 1;

  logic [AW-1:0]         acc;
  logic [AW-1:0]         acc_nxt;
  logic [audio_bits:0]   step;
  logic [audio_bits-1:0] target;

  assign acc_nxt = acc + {{ramp_log2{step[audio_bits]}}, step};

`ifdef AUDIO_INTERP_LINEAR_EN
  // acc holds start*(2^R-k) + target*k, so dropping R low bits is the floor division.
  assign value = acc_nxt[ramp_log2 +: audio_bits];
`else
  assign value = target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      step   <= '0;
      target <= '0;
    end else if (load) begin
      // The new ramp starts from the previous target, which is what d already shows.
      target <= target_in;
      step   <= {target_in[audio_bits-1], target_in} - {target[audio_bits-1], target};
      acc    <= {target[audio_bits-1], target, {ramp_log2{1'b0}}};
    end else if (advance) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/audio_interp.sv
// Sample-rate interpolator: one pending sample, each ramp lasts 2^ramp_log2 cycles; first value 2 cycles after accept.
// in_ready drops while the pending slot is full; optional linear ramp via AUDIO_INTERP_LINEAR_EN.
module audio_interp
  import audio_pkg::*;
#(
  parameter int audio_bits = 16,
  parameter int ramp_log2  = RAMP_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [audio_bits-1:0] in_sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [audio_bits-1:0] d,
  output logic                  underrun
);

  localparam logic [ramp_log2:0] K_ONE  = (ramp_log2 + 1)'(1);
  localparam logic [ramp_log2:0] K_LAST = K_ONE << ramp_log2;

  state_t                state;
  logic [ramp_log2:0]    k;
  logic                  pend_vld;
  logic [audio_bits-1:0] pend_dat;
  logic                  fire;
  logic                  last;
  logic                  consume;
  logic                  pend_nxt;
  logic [audio_bits-1:0] ramp_val;

  always_comb begin
    fire     = in_valid & in_ready;
    last     = (state == RAMP) && (k == K_LAST);
    consume  = pend_vld && ((state == IDLE) || last);
    // fire needs an empty slot and consume a full one, so they never coincide.
    pend_nxt = fire | (pend_vld & ~consume);
  end

  audio_interp_ramp #(
    .audio_bits(audio_bits),
    .ramp_log2 (ramp_log2)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .load     (consume),
    .advance  (state == RAMP),
    .target_in(pend_dat),
    .value    (ramp_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
      in_ready <= 1'b1;
      d        <= '0;
      underrun <= 1'b0;
    end else begin
      pend_vld <= pend_nxt;
      in_ready <= ~pend_nxt;
      if (fire) pend_dat <= in_sample;
      underrun <= last & ~pend_vld;
      if (state == RAMP) d <= ramp_val;
      case (state)
        IDLE: begin
          if (pend_vld) begin
            state <= RAMP;
            k     <= K_ONE;
          end
        end
        RAMP: begin
          if (last) begin
            if (pend_vld) k <= K_ONE;
            else          state <= IDLE;
          end else begin
            k <= k + K_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
